// File: rtl/pipe_ctrl_if.sv
// Control bundle between the Y86-64 fetch/pipeline registers and pipe_ctrl; PIPE_CTRL_PERF_EN adds counters.
// Latency: wires only.
// Backpressure: stall/bubble outputs are the flow control for every pipeline register.
interface pipe_ctrl_if;
    logic [3:0]  f_icode;
    logic [63:0] f_valC;
    logic [63:0] f_valP;
    logic [3:0]  D_icode;
    logic [3:0]  d_srcA;
    logic [3:0]  d_srcB;
    logic [3:0]  E_icode;
    logic [3:0]  E_dstM;
    logic        e_Cnd;
    logic [3:0]  M_icode;
    logic        M_Cnd;
    logic [63:0] M_valA;
    logic [2:0]  m_stat;
    logic [3:0]  W_icode;
    logic [63:0] W_valM;
    logic [2:0]  W_stat;
    logic [63:0] pc;
    logic        F_stall;
    logic        D_stall;
    logic        W_stall;
    logic        D_bubble;
    logic        E_bubble;
    logic        M_bubble;
    logic        halted;
    logic [2:0]  cpu_stat;
`ifdef PIPE_CTRL_PERF_EN
    logic [63:0] cycle_cnt;
    logic [63:0] retire_cnt;
    logic [63:0] stall_cnt;
`endif

    modport master (
        output f_icode, f_valC, f_valP, D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd,
               M_icode, M_Cnd, M_valA, m_stat, W_icode, W_valM, W_stat,
`ifdef PIPE_CTRL_PERF_EN
        input  cycle_cnt, retire_cnt, stall_cnt,
`endif
        input  pc, F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, halted, cpu_stat
    );

    modport slave (
        input  f_icode, f_valC, f_valP, D_icode, d_srcA, d_srcB, E_icode, E_dstM, e_Cnd,
               M_icode, M_Cnd, M_valA, m_stat, W_icode, W_valM, W_stat,
`ifdef PIPE_CTRL_PERF_EN
        output cycle_cnt, retire_cnt, stall_cnt,
`endif
        output pc, F_stall, D_stall, W_stall, D_bubble, E_bubble, M_bubble, halted, cpu_stat
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline controller: fetch PC, hazard stall/bubble generation, status FSM; PIPE_CTRL_PERF_EN adds counters.
// Latency: pc and stall/bubble are combinational from registered state plus inputs; state/predPC update on posedge.
// Backpressure: load-use, ret and mispredict hazards stall or bubble stages; HALTED freezes the whole pipeline.
module pipe_ctrl #(
    parameter logic [63:0] START_PC = 64'h0
) (
    input  logic     clk,
    input  logic     rst_n,
    pipe_ctrl_if.slave pif
);
    localparam logic [3:0] I_MRMOVQ = 4'd5;
    localparam logic [3:0] I_JXX    = 4'd7;
    localparam logic [3:0] I_CALL   = 4'd8;
    localparam logic [3:0] I_RET    = 4'd9;
    localparam logic [3:0] I_POPQ   = 4'd11;
    localparam logic [3:0] I_NOP    = 4'd1;
    localparam logic [3:0] R_NONE   = 4'hF;
    localparam logic [2:0] S_AOK    = 3'd1;

    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_HALTED} state_t;

    state_t      state;
    logic [63:0] pred_pc;
    logic [2:0]  cpu_stat_q;
    logic        halted_q;

    logic load_use, ret_pend, mispred;
    logic f_stall, d_stall, w_stall, d_bubble, e_bubble, m_bubble;

    assign load_use = (pif.E_icode == I_MRMOVQ || pif.E_icode == I_POPQ) && pif.E_dstM != R_NONE &&
                      (pif.E_dstM == pif.d_srcA || pif.E_dstM == pif.d_srcB);
    assign ret_pend = pif.D_icode == I_RET || pif.E_icode == I_RET || pif.M_icode == I_RET;
    assign mispred  = pif.E_icode == I_JXX && !pif.e_Cnd;

    always_comb begin
        f_stall  = 1'b0;
        d_stall  = 1'b0;
        w_stall  = 1'b0;
        d_bubble = 1'b0;
        e_bubble = 1'b0;
        m_bubble = 1'b0;
        case (state)
            ST_INIT: begin
                f_stall  = 1'b1;
                d_bubble = 1'b1;
                e_bubble = 1'b1;
                m_bubble = 1'b1;
            end
            ST_RUN: begin
                f_stall  = load_use || ret_pend;
                // A squashed branch path must never be held; the bubble wins.
                d_stall  = load_use && !mispred;
                d_bubble = mispred || (ret_pend && !load_use);
                e_bubble = mispred || load_use;
                m_bubble = pif.m_stat != S_AOK || pif.W_stat != S_AOK;
                w_stall  = pif.W_stat != S_AOK;
            end
            default: begin
                f_stall  = 1'b1;
                d_stall  = 1'b1;
                w_stall  = 1'b1;
                e_bubble = 1'b1;
                m_bubble = 1'b1;
            end
        endcase
    end

    always_comb begin
        if (pif.M_icode == I_JXX && !pif.M_Cnd)
            pif.pc = pif.M_valA;
        else if (pif.W_icode == I_RET)
            pif.pc = pif.W_valM;
        else
            pif.pc = pred_pc;
    end

    assign pif.F_stall  = f_stall;
    assign pif.D_stall  = d_stall;
    assign pif.W_stall  = w_stall;
    assign pif.D_bubble = d_bubble;
    assign pif.E_bubble = e_bubble;
    assign pif.M_bubble = m_bubble;
    assign pif.halted   = halted_q;
    assign pif.cpu_stat = cpu_stat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_INIT;
            pred_pc    <= START_PC;
            cpu_stat_q <= S_AOK;
            halted_q   <= 1'b0;
        end else begin
            if (!f_stall)
                pred_pc <= (pif.f_icode == I_JXX || pif.f_icode == I_CALL) ? pif.f_valC : pif.f_valP;
            case (state)
                ST_INIT: state <= ST_RUN;
                ST_RUN: begin
                    if (pif.W_stat != S_AOK) begin
                        state      <= ST_HALTED;
                        cpu_stat_q <= pif.W_stat;
                        halted_q   <= 1'b1;
                    end
                end
                default: state <= ST_HALTED;
            endcase
        end
    end

`ifdef PIPE_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pif.cycle_cnt  <= 64'd0;
            pif.retire_cnt <= 64'd0;
            pif.stall_cnt  <= 64'd0;
        end else if (state == ST_RUN) begin
            pif.cycle_cnt <= pif.cycle_cnt + 64'd1;
            if (pif.W_icode != I_NOP && !w_stall)
                pif.retire_cnt <= pif.retire_cnt + 64'd1;
            if (f_stall)
                pif.stall_cnt <= pif.stall_cnt + 64'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed vectors push expectations, a negedge monitor pops and compares.
module tb_pipe_ctrl;
    localparam int ST_INIT = 0;
    localparam int ST_RUN  = 1;
    localparam int ST_HALT = 2;

    logic clk;
    logic rst_n;
    pipe_ctrl_if pif();

    pipe_ctrl #(.START_PC(64'h20)) dut (.clk(clk), .rst_n(rst_n), .pif(pif));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [63:0] pc;
        logic [5:0]  ctl;
        logic        hlt;
        logic [2:0]  stat;
        logic [63:0] cyc;
        logic [63:0] ret;
        logic [63:0] stl;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad   = 0;
    logic [63:0] m_cyc = 0, m_ret = 0, m_stl = 0;

    // ctl order: F_stall D_stall W_stall D_bubble E_bubble M_bubble
    localparam logic [5:0] C_IDLE = 6'b000_000;
    localparam logic [5:0] C_INIT = 6'b100_111;
    localparam logic [5:0] C_HALT = 6'b111_011;
    localparam logic [5:0] C_LU   = 6'b110_010;
    localparam logic [5:0] C_MISP = 6'b000_110;
    localparam logic [5:0] C_RET  = 6'b100_100;

    task automatic idle_inputs();
        pif.f_icode = 4'd1;  pif.f_valC = 64'h0;  pif.f_valP = 64'h0;
        pif.D_icode = 4'd1;  pif.d_srcA = 4'hF;   pif.d_srcB = 4'hF;
        pif.E_icode = 4'd1;  pif.E_dstM = 4'hF;   pif.e_Cnd  = 1'b1;
        pif.M_icode = 4'd1;  pif.M_Cnd  = 1'b1;   pif.M_valA = 64'h0;
        pif.m_stat  = 3'd1;  pif.W_icode = 4'd1;  pif.W_valM = 64'h0;
        pif.W_stat  = 3'd1;
    endtask

    task automatic cyc_start();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic step(input string nm, input int st, input logic [63:0] epc,
                        input logic [5:0] ectl, input logic eh, input logic [2:0] es);
        exp_t e;
        if (!rst_n) begin
            m_cyc = 0; m_ret = 0; m_stl = 0;
        end
        e.name = nm; e.pc = epc; e.ctl = ectl; e.hlt = eh; e.stat = es;
        e.cyc = m_cyc; e.ret = m_ret; e.stl = m_stl;
        exp_q.push_back(e);
        if (st == ST_RUN && rst_n) begin
            m_cyc = m_cyc + 1;
            if (ectl[5]) m_stl = m_stl + 1;
            if (pif.W_icode != 4'd1 && !ectl[3]) m_ret = m_ret + 1;
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [5:0] act;
            logic ok;
            e = exp_q.pop_front();
            act = {pif.F_stall, pif.D_stall, pif.W_stall, pif.D_bubble, pif.E_bubble, pif.M_bubble};
            ok = (pif.pc === e.pc) && (act === e.ctl) && (pif.halted === e.hlt) && (pif.cpu_stat === e.stat);
`ifdef PIPE_CTRL_PERF_EN
            ok = ok && (pif.cycle_cnt === e.cyc) && (pif.retire_cnt === e.ret) && (pif.stall_cnt === e.stl);
            if (!ok)
                $display("FAIL %s: cnt cyc/ret/stl got %0d/%0d/%0d want %0d/%0d/%0d", e.name,
                         pif.cycle_cnt, pif.retire_cnt, pif.stall_cnt, e.cyc, e.ret, e.stl);
`endif
            total = total + 1;
            if (!ok) begin
                bad = bad + 1;
                $display("FAIL %s: pc=%h ctl=%b halted=%b stat=%0d, want pc=%h ctl=%b halted=%b stat=%0d",
                         e.name, pif.pc, act, pif.halted, pif.cpu_stat, e.pc, e.ctl, e.hlt, e.stat);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        // Reset and INIT
        cyc_start(); pif.f_valP = 64'h2a;
        step("reset_hold", ST_INIT, 64'h20, C_INIT, 1'b0, 3'd1);
        cyc_start(); rst_n = 1'b1; pif.f_valP = 64'h2a;
        step("init_cycle", ST_INIT, 64'h20, C_INIT, 1'b0, 3'd1);
        cyc_start(); pif.f_valP = 64'h2a;
        step("first_run", ST_RUN, 64'h20, C_IDLE, 1'b0, 3'd1);
        cyc_start(); pif.f_icode = 4'd7; pif.f_valC = 64'h80; pif.f_valP = 64'h33;
        step("pred_valP", ST_RUN, 64'h2a, C_IDLE, 1'b0, 3'd1);
        cyc_start(); pif.f_icode = 4'd8; pif.f_valC = 64'h90; pif.f_valP = 64'h89;
        step("pred_jxx", ST_RUN, 64'h80, C_IDLE, 1'b0, 3'd1);
        cyc_start(); pif.f_valP = 64'h99;
        step("pred_call", ST_RUN, 64'h90, C_IDLE, 1'b0, 3'd1);
        // Load-use hazards
        cyc_start(); pif.E_icode = 4'd5; pif.E_dstM = 4'd3; pif.d_srcA = 4'd3; pif.f_valP = 64'hA0;
        step("load_use_a", ST_RUN, 64'h99, C_LU, 1'b0, 3'd1);
        cyc_start(); pif.f_valP = 64'hA0;
        step("load_use_after", ST_RUN, 64'h99, C_IDLE, 1'b0, 3'd1);
        cyc_start(); pif.E_icode = 4'd11; pif.E_dstM = 4'd4; pif.d_srcB = 4'd4; pif.f_valP = 64'hA8;
        step("load_use_popq_b", ST_RUN, 64'hA0, C_LU, 1'b0, 3'd1);
        cyc_start(); pif.E_icode = 4'd5; pif.E_dstM = 4'd3; pif.d_srcA = 4'd2; pif.f_valP = 64'hA8;
        step("no_hazard_diff_reg", ST_RUN, 64'hA0, C_IDLE, 1'b0, 3'd1);
        // Mispredicted branch
        cyc_start(); pif.E_icode = 4'd7; pif.e_Cnd = 1'b0; pif.f_valP = 64'hB0;
        step("mispred_e", ST_RUN, 64'hA8, C_MISP, 1'b0, 3'd1);
        cyc_start(); pif.M_icode = 4'd7; pif.M_Cnd = 1'b0; pif.M_valA = 64'h40; pif.f_valP = 64'h4a;
        step("mispred_fix_pc", ST_RUN, 64'h40, C_IDLE, 1'b0, 3'd1);
        cyc_start(); pif.M_icode = 4'd7; pif.M_Cnd = 1'b1; pif.M_valA = 64'h40; pif.f_valP = 64'h54;
        step("taken_no_fix", ST_RUN, 64'h4a, C_IDLE, 1'b0, 3'd1);
        // Return traversing D, E, M, then W
        cyc_start(); pif.D_icode = 4'd9; pif.f_valP = 64'h60;
        step("ret_in_d", ST_RUN, 64'h54, C_RET, 1'b0, 3'd1);
        cyc_start(); pif.E_icode = 4'd9; pif.f_valP = 64'h60;
        step("ret_in_e", ST_RUN, 64'h54, C_RET, 1'b0, 3'd1);
        cyc_start(); pif.M_icode = 4'd9; pif.f_valP = 64'h60;
        step("ret_in_m", ST_RUN, 64'h54, C_RET, 1'b0, 3'd1);
        cyc_start(); pif.W_icode = 4'd9; pif.W_valM = 64'h100; pif.f_valP = 64'h101;
        step("ret_in_w", ST_RUN, 64'h100, C_IDLE, 1'b0, 3'd1);
        cyc_start(); pif.f_valP = 64'h10a;
        step("after_ret", ST_RUN, 64'h101, C_IDLE, 1'b0, 3'd1);
        // ret pending while a load-use stalls decode
        cyc_start(); pif.D_icode = 4'd9; pif.E_icode = 4'd5; pif.E_dstM = 4'd3; pif.d_srcA = 4'd3;
        step("ret_and_load_use", ST_RUN, 64'h10a, C_LU, 1'b0, 3'd1);
        cyc_start(); pif.f_valP = 64'h110;
        step("after_ret_lu", ST_RUN, 64'h10a, C_IDLE, 1'b0, 3'd1);
        cyc_start(); pif.m_stat = 3'd3; pif.f_valP = 64'h118;
        step("m_stat_adr", ST_RUN, 64'h110, 6'b000_001, 1'b0, 3'd1);
        // Halt on INS
        cyc_start(); pif.W_stat = 3'd4; pif.f_valP = 64'h120;
        step("w_stat_ins", ST_RUN, 64'h118, 6'b001_001, 1'b0, 3'd1);
        cyc_start(); pif.f_valP = 64'h200;
        step("halted_1", ST_HALT, 64'h120, C_HALT, 1'b1, 3'd4);
        cyc_start(); pif.f_valP = 64'h200; pif.e_Cnd = 1'b0; pif.E_icode = 4'd7;
        step("halted_2", ST_HALT, 64'h120, C_HALT, 1'b1, 3'd4);
        cyc_start(); pif.W_stat = 3'd2;
        step("halted_3", ST_HALT, 64'h120, C_HALT, 1'b1, 3'd4);
        // Asynchronous reset from HALTED
        cyc_start(); rst_n = 1'b0;
        step("async_reset", ST_INIT, 64'h20, C_INIT, 1'b0, 3'd1);
        cyc_start(); rst_n = 1'b1; pif.f_valP = 64'h28;
        step("reinit", ST_INIT, 64'h20, C_INIT, 1'b0, 3'd1);
        cyc_start(); pif.f_valP = 64'h28;
        step("rerun", ST_RUN, 64'h20, C_IDLE, 1'b0, 3'd1);
        cyc_start(); pif.f_valP = 64'h30;
        step("rerun_adv", ST_RUN, 64'h28, C_IDLE, 1'b0, 3'd1);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            total = total + 1;
            bad = bad + 1;
            $display("FAIL drain: pending=%0d want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
